// File: rtl/vsu_strb.sv
// Vector store unit with a strobed tail beat, zero-length requests and synchronous flush.
// Each lane pushes one VRF word into its own FIFO. The unit emits each row of lane words as
// NrLanes/OutWordsPerBeat output beats, with a byte strobe on the tail beat, and then reports
// completion to the committer.
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   req_valid_i/req_ready_o        store request handshake; req_vlb_i bytes, req_id_i id
//   lane_valid_i/lane_ready_o      per-lane operand push; lane_data_i packed lane words
//   out_valid_o/out_ready_i        output beat handshake; out_data_o, out_strb_o, out_last_o
//   flush_i                        abort current instruction and drop buffered operands
//   done_o, done_id_o              one-cycle completion pulse with instruction id
//   busy_o                         unit not idle
module vsu_strb #(
  parameter int unsigned NrLanes         = 4,
  parameter int unsigned LaneWordW       = 64,
  parameter int unsigned InBufDepth      = 4,
  parameter int unsigned OutWordsPerBeat = 1,
  parameter int unsigned VlBWidth        = 16,
  parameter int unsigned IdWidth         = 3
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   req_valid_i,
  output logic                                   req_ready_o,
  input  logic [VlBWidth-1:0]                    req_vlb_i,
  input  logic [IdWidth-1:0]                     req_id_i,
  input  logic [NrLanes-1:0]                     lane_valid_i,
  output logic [NrLanes-1:0]                     lane_ready_o,
  input  logic [NrLanes*LaneWordW-1:0]           lane_data_i,
  output logic                                   out_valid_o,
  input  logic                                   out_ready_i,
  output logic [OutWordsPerBeat*LaneWordW-1:0]   out_data_o,
  output logic [OutWordsPerBeat*LaneWordW/8-1:0] out_strb_o,
  output logic                                   out_last_o,
  input  logic                                   flush_i,
  output logic                                   done_o,
  output logic [IdWidth-1:0]                     done_id_o,
  output logic                                   busy_o
);

  localparam int unsigned LaneWordB = LaneWordW / 8;
  localparam int unsigned BeatW     = OutWordsPerBeat * LaneWordW;
  localparam int unsigned BeatB     = OutWordsPerBeat * LaneWordB;
  localparam int unsigned NrBeats   = NrLanes / OutWordsPerBeat;
  localparam int unsigned BcW       = (NrBeats > 1) ? $clog2(NrBeats) : 1;
  localparam int unsigned PtrW      = $clog2(InBufDepth);
  localparam int unsigned CntW      = $clog2(InBufDepth + 1);
  localparam logic [VlBWidth-1:0] BeatBV = VlBWidth'(BeatB);

  typedef enum logic [1:0] {IDLE, STORE, ZDONE} state_e;

  state_e              state_q, state_d;
  logic [IdWidth-1:0]  id_q, id_d;
  logic [VlBWidth-1:0] rem_q, rem_d;
  logic [BcW-1:0]      beat_q, beat_d;

  logic [LaneWordW-1:0] mem_q    [NrLanes][InBufDepth];
  logic [PtrW-1:0]      wr_ptr_q [NrLanes];
  logic [PtrW-1:0]      wr_ptr_d [NrLanes];
  logic [PtrW-1:0]      rd_ptr_q [NrLanes];
  logic [PtrW-1:0]      rd_ptr_d [NrLanes];
  logic [CntW-1:0]      cnt_q    [NrLanes];
  logic [CntW-1:0]      cnt_d    [NrLanes];

  logic [NrLanes-1:0]           empty, full, push;
  logic [NrLanes*LaneWordW-1:0] head_flat;
  logic                         pop_all;
  logic                         valid_c, last_c, load_c;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(InBufDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  // FIFO status and head words; pushes are dropped during flush
  always_comb begin
    for (int i = 0; i < NrLanes; i++) begin
      empty[i]        = (cnt_q[i] == '0);
      full[i]         = (cnt_q[i] == CntW'(InBufDepth));
      lane_ready_o[i] = ~full[i];
      push[i]         = lane_valid_i[i] & ~full[i] & ~flush_i;
      head_flat[i*LaneWordW +: LaneWordW] = mem_q[i][rd_ptr_q[i]];
    end
  end

  // FIFO pointer and occupancy update; all lanes pop together at the end of a row
  always_comb begin
    for (int i = 0; i < NrLanes; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      cnt_d[i]    = cnt_q[i];
      if (push[i]) wr_ptr_d[i] = ptr_inc(wr_ptr_q[i]);
      if (pop_all) rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);
      cnt_d[i] = cnt_q[i] + CntW'(push[i]) - CntW'(pop_all);
      if (flush_i) begin
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
        cnt_d[i]    = '0;
      end
    end
  end

  // Next state and beat outputs
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    rem_d       = rem_q;
    beat_d      = beat_q;
    req_ready_o = 1'b0;
    out_valid_o = 1'b0;
    out_data_o  = '0;
    out_strb_o  = '0;
    out_last_o  = 1'b0;
    done_o      = 1'b0;
    done_id_o   = id_q;
    pop_all     = 1'b0;
    load_c      = 1'b0;
    valid_c     = 1'b0;
    last_c      = (rem_q <= BeatBV);

    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        load_c      = req_valid_i;
      end
      ZDONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      STORE: begin
        valid_c     = &(~empty);
        out_valid_o = valid_c;
        if (valid_c) begin
          for (int b = 0; b < NrBeats; b++) begin
            if (beat_q == BcW'(b)) out_data_o = head_flat[b*BeatW +: BeatW];
          end
          for (int j = 0; j < BeatB; j++) begin
            out_strb_o[j] = (VlBWidth'(j) < rem_q);
          end
          out_last_o = last_c;
        end
        if (valid_c && out_ready_i) begin
          rem_d   = (rem_q > BeatBV) ? rem_q - BeatBV : '0;
          // a partial tail row is popped whole
          pop_all = (beat_q == BcW'(NrBeats - 1)) || last_c;
          beat_d  = pop_all ? '0 : beat_q + 1'b1;
          if (last_c) begin
            done_o      = 1'b1;
            req_ready_o = 1'b1;
            state_d     = IDLE;
            load_c      = req_valid_i;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // new request, possibly back-to-back with the previous last beat
    if (load_c) begin
      id_d    = req_id_i;
      rem_d   = req_vlb_i;
      beat_d  = '0;
      state_d = (req_vlb_i == '0) ? ZDONE : STORE;
    end

    if (flush_i) begin
      state_d     = IDLE;
      rem_d       = '0;
      beat_d      = '0;
      req_ready_o = 1'b0;
      out_valid_o = 1'b0;
      out_data_o  = '0;
      out_strb_o  = '0;
      out_last_o  = 1'b0;
      done_o      = 1'b0;
      pop_all     = 1'b0;
      state_d     = IDLE;
    end
  end

  assign busy_o = (state_q != IDLE);

  // Control registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      id_q    <= '0;
      rem_q   <= '0;
      beat_q  <= '0;
      for (int i = 0; i < NrLanes; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      rem_q   <= rem_d;
      beat_q  <= beat_d;
      for (int i = 0; i < NrLanes; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

  // FIFO storage, no reset needed
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NrLanes; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= lane_data_i[i*LaneWordW +: LaneWordW];
    end
  end

endmodule
